// File: rtl/regfile_write_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sched_pkg
// Shared types for the register-file write scheduler:
//   wr_req_t      - one queued register write (destination + data)
//   sched_state_e - run / drain sequencing states
//   PC_REG        - r15, never written through the scheduler
//   addr_legal()  - true for destinations the scheduler may write
// -----------------------------------------------------------------------------
package regfile_sched_pkg;

  localparam logic [4:0] PC_REG = 5'd15;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    WAIT  = 2'd3
  } sched_state_e;

  // Anything at or above the PC register (including 16..31) is dropped.
  function automatic logic addr_legal(input logic [4:0] addr);
    return (addr < PC_REG);
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_chk.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler_chk
// Protocol checker: a requester must not enqueue a register that is still
// busy because of the other requester (cross-requester WAW is not ordered).
// Ports: clk, rst, the two legal-push strobes with their addresses, and the
// busy contribution of each requester (its FIFO plus the port if it issued).
// -----------------------------------------------------------------------------
module regfile_write_scheduler_chk #(
  parameter int NREG = 16
) (
  input logic            clk,
  input logic            rst,
  input logic            alu_push,
  input logic [4:0]      alu_addr,
  input logic            lsu_push,
  input logic [4:0]      lsu_addr,
  input logic [NREG-1:0] alu_side,
  input logic [NREG-1:0] lsu_side
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  a_alu_no_cross_waw: assert property (@(posedge clk) disable iff (!rst)
    alu_push |-> ((lsu_side & (ONE << alu_addr)) == {NREG{1'b0}}));

  a_lsu_no_cross_waw: assert property (@(posedge clk) disable iff (!rst)
    lsu_push |-> ((alu_side & (ONE << lsu_addr)) == {NREG{1'b0}}));

endmodule

// File: rtl/regfile_write_scheduler_wr_fifo.sv
// -----------------------------------------------------------------------------
// wr_fifo
// Small synchronous FIFO of register writes. The raw storage and a per-slot
// valid vector are exported so the owner can build a busy mask.
// Ports:
//   clk, rst      clock, synchronous active-low reset (empties the FIFO)
//   push/push_data  enqueue (caller guarantees !full or simultaneous pop)
//   pop             dequeue head
//   full, empty     occupancy flags
//   head            oldest entry
//   entries         storage array, entry_valid marks occupied slots
// -----------------------------------------------------------------------------
module wr_fifo
  import regfile_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wr_req_t          push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output wr_req_t          head,
  output wr_req_t          entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam int AW = $clog2(DEPTH);

  wr_req_t       mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: slots are only observed through entry_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, AW'(i) - rd_ptr} < count);
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_write_scheduler
// Shares the single register-file write port between ALU and LSU writeback.
// Each requester has a DEPTH-entry FIFO; a round-robin arbiter issues at most
// one registered write per cycle. Also exports a busy mask and a drain
// handshake (drain_req level in, drain_done pulse out).
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   alu_valid/ready/addr/data     ALU write request
//   lsu_valid/ready/addr/data     LSU write request
//   rf_hold                       suppress issue this cycle
//   drain_req, drain_done         drain handshake
//   rf_we, rf_a3, rf_wd3          register-file write port (registered)
//   busy_mask                     registers with a write queued or on the port
//   drop_cnt                      saturating count of illegal (>=r15) requests
// Optional build macro RFSCHED_DBG_PORT_EN adds an unbuffered debug requester
// (dbg_valid/dbg_ready/dbg_addr/dbg_data) with top priority.
// -----------------------------------------------------------------------------
module regfile_write_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_addr,
  input  logic [31:0]     alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_addr,
  input  logic [31:0]     lsu_data,
  input  logic            rf_hold,
  input  logic            drain_req,
  output logic            drain_done,
`ifdef RFSCHED_DBG_PORT_EN
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic [4:0]      dbg_addr,
  input  logic [31:0]     dbg_data,
`endif
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [31:0]     rf_wd3,
  output logic [NREG-1:0] busy_mask,
  output logic [7:0]      drop_cnt
);

  sched_state_e     state, state_next;
  logic             full_a, empty_a, full_l, empty_l;
  wr_req_t          head_a, head_l, issue_req, dbg_req;
  wr_req_t          ent_a [DEPTH];
  wr_req_t          ent_l [DEPTH];
  logic [DEPTH-1:0] val_a, val_l;
  logic             fire_a, fire_l, push_a, push_l, drop_a, drop_l, drop_dbg;
  logic             grant_a, grant_l, grant_dbg, issue;
  logic             rr_lsu;      // 1: LSU wins the next tie
  logic             issued_alu, issued_lsu;
  logic [NREG-1:0]  mask_a, mask_l, mask_port;
  logic [9:0]       drop_sum;

  // Ready is a function of registered state only, so it is settled before the
  // edge even when the same edge pops the FIFO.
  assign alu_ready = rst && (state == RUN) && !full_a;
  assign lsu_ready = rst && (state == RUN) && !full_l;
  assign fire_a    = alu_valid && alu_ready;
  assign fire_l    = lsu_valid && lsu_ready;
  assign push_a    = fire_a && addr_legal(alu_addr);
  assign push_l    = fire_l && addr_legal(lsu_addr);
  assign drop_a    = fire_a && !addr_legal(alu_addr);
  assign drop_l    = fire_l && !addr_legal(lsu_addr);

`ifdef RFSCHED_DBG_PORT_EN
  assign dbg_ready = !rf_hold;
  assign grant_dbg = dbg_valid && dbg_ready && addr_legal(dbg_addr);
  assign drop_dbg  = dbg_valid && dbg_ready && !addr_legal(dbg_addr);
  assign dbg_req   = '{addr: dbg_addr, data: dbg_data};
`else
  assign grant_dbg = 1'b0;
  assign drop_dbg  = 1'b0;
  assign dbg_req   = '{addr: 5'd0, data: 32'd0};
`endif

  wr_fifo #(.DEPTH(DEPTH)) u_fifo_alu (
    .clk(clk), .rst(rst), .push(push_a), .push_data('{addr: alu_addr, data: alu_data}),
    .pop(grant_a), .full(full_a), .empty(empty_a), .head(head_a),
    .entries(ent_a), .entry_valid(val_a)
  );

  wr_fifo #(.DEPTH(DEPTH)) u_fifo_lsu (
    .clk(clk), .rst(rst), .push(push_l), .push_data('{addr: lsu_addr, data: lsu_data}),
    .pop(grant_l), .full(full_l), .empty(empty_l), .head(head_l),
    .entries(ent_l), .entry_valid(val_l)
  );

  // Arbitration: debug (if present) first, then round-robin between FIFO heads.
  always_comb begin
    grant_a = 1'b0;
    grant_l = 1'b0;
    if (rf_hold || grant_dbg) begin
      grant_a = 1'b0;
      grant_l = 1'b0;
    end else if (!empty_a && (empty_l || !rr_lsu)) begin
      grant_a = 1'b1;
    end else if (!empty_l) begin
      grant_l = 1'b1;
    end else begin
      grant_l = 1'b0;
    end
    if (grant_dbg)    issue_req = dbg_req;
    else if (grant_l) issue_req = head_l;
    else              issue_req = head_a;
  end

  assign issue    = grant_dbg || grant_a || grant_l;
  assign drop_sum = {2'b00, drop_cnt} + {9'd0, drop_a} + {9'd0, drop_l} + {9'd0, drop_dbg};

  // Busy contributions: each FIFO's live entries, plus the write on the port.
  always_comb begin
    mask_a    = {NREG{1'b0}};
    mask_l    = {NREG{1'b0}};
    mask_port = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mask_a[r] = mask_a[r] | (val_a[i] && (ent_a[i].addr == 5'(r)));
        mask_l[r] = mask_l[r] | (val_l[i] && (ent_l[i].addr == 5'(r)));
      end
      mask_port[r] = rf_we && (rf_a3 == 5'(r));
    end
  end

  assign busy_mask = mask_a | mask_l | mask_port;

  // Drain sequencing.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (drain_req) state_next = DRAIN; else state_next = RUN;
      DRAIN:   if (empty_a && empty_l && !rf_we) state_next = DONE; else state_next = DRAIN;
      DONE:    if (drain_req) state_next = WAIT; else state_next = RUN;
      WAIT:    if (!drain_req) state_next = RUN; else state_next = WAIT;
      default: state_next = RUN;
    endcase
  end

  assign drain_done = (state == DONE);

  // Write port, arbiter pointer, drop counter and FSM state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      rf_we      <= 1'b0;
      rf_a3      <= 5'd0;
      rf_wd3     <= 32'd0;
      drop_cnt   <= 8'd0;
      rr_lsu     <= 1'b0;
      issued_alu <= 1'b0;
      issued_lsu <= 1'b0;
    end else begin
      state      <= state_next;
      rf_we      <= issue;
      issued_alu <= grant_a;
      issued_lsu <= grant_l;
      drop_cnt   <= (drop_sum > 10'd255) ? 8'd255 : drop_sum[7:0];
      if (issue) begin
        rf_a3  <= issue_req.addr;
        rf_wd3 <= issue_req.data;
      end
      // Pointer moves away from whichever FIFO just won.
      if (grant_a)      rr_lsu <= 1'b1;
      else if (grant_l) rr_lsu <= 1'b0;
    end
  end

  regfile_write_scheduler_chk #(.NREG(NREG)) u_chk (
    .clk(clk), .rst(rst),
    .alu_push(push_a), .alu_addr(alu_addr),
    .lsu_push(push_l), .lsu_addr(lsu_addr),
    .alu_side(mask_a | (mask_port & {NREG{issued_alu}})),
    .lsu_side(mask_l | (mask_port & {NREG{issued_lsu}}))
  );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_scheduler
// Directed vector table, hand-written drain/reset/drop sequences, and a
// randomized run checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_regfile_write_scheduler;

  localparam int DEPTH = 2;
  localparam int NV    = 21;

  logic        clk = 1'b0;
  logic        rst, alu_valid, lsu_valid, rf_hold, drain_req;
  logic [4:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, drain_done, rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [15:0] busy_mask;
  logic [7:0]  drop_cnt;
`ifdef RFSCHED_DBG_PORT_EN
  logic        dbg_valid = 1'b0;
  logic        dbg_ready;
  logic [4:0]  dbg_addr  = 5'd0;
  logic [31:0] dbg_data  = 32'd0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.DEPTH(DEPTH), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .rf_hold(rf_hold), .drain_req(drain_req), .drain_done(drain_done),
`ifdef RFSCHED_DBG_PORT_EN
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .busy_mask(busy_mask), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'd0;
    rf_hold = 1'b0; drain_req = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, hold, av;  logic [4:0] aa; logic [31:0] ad;
    logic lv;             logic [4:0] la; logic [31:0] ld;
    logic we;             logic [4:0] a3; logic [31:0] wd3;
    logic [15:0] busy;    logic ar, lr;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic h,
                              input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic we, input logic [4:0] a3, input logic [31:0] wd3,
                              input logic [15:0] busy, input logic ar, input logic lr);
    vec_t v;
    v.rst = r; v.hold = h; v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.we = we; v.a3 = a3; v.wd3 = wd3; v.busy = busy; v.ar = ar; v.lr = lr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] addr; logic [31:0] data; } req_t;
  req_t        mq_a[$];
  req_t        mq_l[$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  int          m_drop;
  bit          lsu_won_last;   // least-recently-granted FIFO wins ties

  function automatic logic [15:0] model_busy();
    logic [15:0] m;
    m = 16'd0;
    foreach (mq_a[i]) m[mq_a[i].addr[3:0]] = 1'b1;
    foreach (mq_l[i]) m[mq_l[i].addr[3:0]] = 1'b1;
    if (m_we) m[m_a3[3:0]] = 1'b1;
    return m;
  endfunction

  initial begin
    int   r, writes, pulses;
    logic [4:0] wr_order [2];
    bit   pa, pl, ma_rdy, ml_rdy, ga, gl;
    req_t e;

    vecs[0]  = mk(1,0, 1,5'd3,32'hDEADBEEF, 0,5'd0,32'd0, 0,5'd0,32'd0,         16'h0008,1,1);
    vecs[1]  = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0, 1,5'd3,32'hDEADBEEF,  16'h0008,1,1);
    vecs[2]  = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0, 0,5'd3,32'hDEADBEEF,  16'h0000,1,1);
    vecs[3]  = mk(0,0, 0,5'd0,32'd0,        0,5'd0,32'd0, 0,5'd0,32'd0,         16'h0000,0,0);
    vecs[4]  = mk(1,0, 1,5'd1,32'hA1,       1,5'd5,32'hB5, 0,5'd0,32'd0,        16'h0022,1,1);
    vecs[5]  = mk(1,0, 1,5'd2,32'hA2,       1,5'd6,32'hB6, 1,5'd1,32'hA1,       16'h0066,1,0);
    vecs[6]  = mk(1,0, 1,5'd3,32'hA3,       1,5'd7,32'hB7, 1,5'd5,32'hB5,       16'h006C,0,1);
    vecs[7]  = mk(1,0, 1,5'd4,32'hA4,       1,5'd7,32'hB7, 1,5'd2,32'hA2,       16'h00CC,1,0);
    vecs[8]  = mk(1,0, 1,5'd4,32'hA4,       1,5'd8,32'hB8, 1,5'd6,32'hB6,       16'h00D8,0,1);
    vecs[9]  = mk(1,0, 0,5'd0,32'd0,        1,5'd8,32'hB8, 1,5'd3,32'hA3,       16'h0198,1,0);
    vecs[10] = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0,  1,5'd7,32'hB7,       16'h0190,1,1);
    vecs[11] = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0,  1,5'd4,32'hA4,       16'h0110,1,1);
    vecs[12] = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0,  1,5'd8,32'hB8,       16'h0100,1,1);
    vecs[13] = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0,  0,5'd8,32'hB8,       16'h0000,1,1);
    vecs[14] = mk(1,1, 1,5'd9,32'hC9,       0,5'd0,32'd0,  0,5'd8,32'hB8,       16'h0200,1,1);
    vecs[15] = mk(1,1, 1,5'd10,32'hCA,      0,5'd0,32'd0,  0,5'd8,32'hB8,       16'h0600,0,1);
    vecs[16] = mk(1,1, 1,5'd11,32'hCB,      0,5'd0,32'd0,  0,5'd8,32'hB8,       16'h0600,0,1);
    vecs[17] = mk(1,0, 1,5'd11,32'hCB,      0,5'd0,32'd0,  1,5'd9,32'hC9,       16'h0600,1,1);
    vecs[18] = mk(1,0, 1,5'd11,32'hCB,      0,5'd0,32'd0,  1,5'd10,32'hCA,      16'h0C00,1,1);
    vecs[19] = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0,  1,5'd11,32'hCB,      16'h0800,1,1);
    vecs[20] = mk(1,0, 0,5'd0,32'd0,        0,5'd0,32'd0,  0,5'd11,32'hCB,      16'h0000,1,1);

    // ---- reset state ----
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    check("reset_rf_we",      32'(rf_we),      32'd0);
    check("reset_rf_a3",      32'(rf_a3),      32'd0);
    check("reset_rf_wd3",     rf_wd3,          32'd0);
    check("reset_busy_mask",  32'(busy_mask),  32'd0);
    check("reset_drop_cnt",   32'(drop_cnt),   32'd0);
    check("reset_drain_done", 32'(drain_done), 32'd0);
    check("reset_alu_ready",  32'(alu_ready),  32'd0);
    check("reset_lsu_ready",  32'(lsu_ready),  32'd0);

    // ---- table: latency, alternation, hold/backpressure ----
    for (int k = 0; k < NV; k++) begin
      rst = vecs[k].rst; rf_hold = vecs[k].hold;
      alu_valid = vecs[k].av; alu_addr = vecs[k].aa; alu_data = vecs[k].ad;
      lsu_valid = vecs[k].lv; lsu_addr = vecs[k].la; lsu_data = vecs[k].ld;
      step();
      check($sformatf("vec%0d_rf_we", k),     32'(rf_we),     32'(vecs[k].we));
      check($sformatf("vec%0d_rf_a3", k),     32'(rf_a3),     32'(vecs[k].a3));
      check($sformatf("vec%0d_rf_wd3", k),    rf_wd3,         vecs[k].wd3);
      check($sformatf("vec%0d_busy", k),      32'(busy_mask), 32'(vecs[k].busy));
      check($sformatf("vec%0d_alu_ready", k), 32'(alu_ready), 32'(vecs[k].ar));
      check($sformatf("vec%0d_lsu_ready", k), 32'(lsu_ready), 32'(vecs[k].lr));
      check($sformatf("vec%0d_drop", k),      32'(drop_cnt),  32'd0);
    end

    // ---- illegal addresses and drop counter saturation ----
    idle_inputs();
    alu_valid = 1'b1; alu_addr = 5'd15; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_addr = 5'd20; lsu_data = 32'h2;
    step();
    check("illegal_drop_cnt", 32'(drop_cnt),  32'd2);
    check("illegal_busy",     32'(busy_mask), 32'd0);
    check("illegal_rf_we0",   32'(rf_we),     32'd0);
    alu_addr = 5'd31; lsu_addr = 5'd16;
    for (int k = 0; k < 150; k++) begin
      step();
      check($sformatf("sat_drop_%0d", k), 32'(drop_cnt),
            32'((2 + 2 * (k + 1) > 255) ? 255 : 2 + 2 * (k + 1)));
      check($sformatf("sat_rf_we_%0d", k), 32'(rf_we), 32'd0);
    end
    check("sat_alu_ready", 32'(alu_ready), 32'd1);

    // ---- reset with queued entries ----
    idle_inputs();
    rf_hold = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd2;  alu_data = 32'h22;
    lsu_valid = 1'b1; lsu_addr = 5'd10; lsu_data = 32'hAA;
    step();
    check("q_before_rst_busy", 32'(busy_mask), 32'h0404);
    idle_inputs();
    rst = 1'b0;
    step();
    check("midrst_rf_we",     32'(rf_we),     32'd0);
    check("midrst_busy",      32'(busy_mask), 32'd0);
    check("midrst_drop",      32'(drop_cnt),  32'd0);
    check("midrst_alu_ready", 32'(alu_ready), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("postrst_rf_we_%0d", k), 32'(rf_we), 32'd0);
    end

    // ---- drain with two queued writes ----
    rf_hold = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
    step();
    idle_inputs();
    drain_req = 1'b1;
    writes = 0; pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rf_we) begin
        if (writes < 2) wr_order[writes] = rf_a3;
        writes++;
      end
      if (drain_done) begin
        pulses++;
        check("drain_done_busy", 32'(busy_mask), 32'd0);
      end
      check($sformatf("drain_alu_ready_%0d", k), 32'(alu_ready), 32'd0);
      check($sformatf("drain_lsu_ready_%0d", k), 32'(lsu_ready), 32'd0);
    end
    check("drain_writes", 32'(writes), 32'd2);
    check("drain_pulses", 32'(pulses), 32'd1);
    if (writes >= 2) begin
      check("drain_first_a3",  32'(wr_order[0]), 32'd1);
      check("drain_second_a3", 32'(wr_order[1]), 32'd9);
    end
    drain_req = 1'b0;
    step();
    check("after_wait_alu_ready", 32'(alu_ready), 32'd1);
    check("after_wait_lsu_ready", 32'(lsu_ready), 32'd1);

    // ---- drain while already empty: DRAIN then DONE on the next edge ----
    drain_req = 1'b1;
    step();
    check("empty_drain_done0", 32'(drain_done), 32'd0);
    check("empty_drain_ready", 32'(alu_ready),  32'd0);
    drain_req = 1'b0;
    step();
    check("empty_drain_done1", 32'(drain_done), 32'd1);
    step();
    check("empty_drain_done2", 32'(drain_done), 32'd0);
    check("empty_drain_back",  32'(alu_ready),  32'd1);

    // ---- randomized run against the reference model ----
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mq_a.delete(); mq_l.delete();
    m_we = 1'b0; m_a3 = 5'd0; m_wd3 = 32'd0; m_drop = 0; lsu_won_last = 1'b1;
    pa = 1'b0; pl = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      // ALU uses r0..r6, LSU r7..r14, so the two never collide on a register.
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1'b1;
        r = $urandom_range(0, 8);
        alu_addr = (r < 7) ? 5'(r) : 5'($urandom_range(15, 31));
        alu_data = $urandom;
      end
      if (!pl && $urandom_range(0, 9) < 6) begin
        pl = 1'b1;
        r = $urandom_range(0, 9);
        lsu_addr = (r < 8) ? 5'(7 + r) : 5'($urandom_range(15, 31));
        lsu_data = $urandom;
      end
      alu_valid = pa; lsu_valid = pl;
      rf_hold = ($urandom_range(0, 4) == 0);
      #1;
      ma_rdy = (mq_a.size() < DEPTH);
      ml_rdy = (mq_l.size() < DEPTH);
      check("rnd_alu_ready", 32'(alu_ready), 32'(ma_rdy));
      check("rnd_lsu_ready", 32'(lsu_ready), 32'(ml_rdy));

      // One write leaves per cycle; ties go to whoever waited longer.
      ga = 1'b0; gl = 1'b0;
      if (!rf_hold) begin
        if (mq_a.size() > 0 && mq_l.size() > 0) begin
          if (lsu_won_last) ga = 1'b1; else gl = 1'b1;
        end else if (mq_a.size() > 0) ga = 1'b1;
        else if (mq_l.size() > 0) gl = 1'b1;
      end
      m_we = ga || gl;
      if (ga) begin e = mq_a.pop_front(); m_a3 = e.addr; m_wd3 = e.data; lsu_won_last = 1'b0; end
      if (gl) begin e = mq_l.pop_front(); m_a3 = e.addr; m_wd3 = e.data; lsu_won_last = 1'b1; end
      if (pa && ma_rdy) begin
        if (alu_addr >= 5'd15) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else mq_a.push_back('{alu_addr, alu_data});
        pa = 1'b0;
      end
      if (pl && ml_rdy) begin
        if (lsu_addr >= 5'd15) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else mq_l.push_back('{lsu_addr, lsu_data});
        pl = 1'b0;
      end

      step();
      check("rnd_rf_we",  32'(rf_we),     32'(m_we));
      check("rnd_rf_a3",  32'(rf_a3),     32'(m_a3));
      check("rnd_rf_wd3", rf_wd3,         m_wd3);
      check("rnd_busy",   32'(busy_mask), 32'(model_busy()));
      check("rnd_drop",   32'(drop_cnt),  32'(m_drop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
